mips_muldiv: RTL

- Iterative multiply/divide unit in the execute stage, alongside the ALU; takes the same A/B operands from the register-read stage.
- Implements MULT, MULTU, DIV, DIVU plus MTHI/MTLO writes.
- Results are held in architectural HI/LO registers that MFHI/MFLO read directly.
- Pipeline control stalls on busy.

---
 rtl/mips_muldiv.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/mips_muldiv.sv
// Iterative 32-bit MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// Optional build macro MULDIV_EARLY_TERM_EN: multiplies leave RUN once the remaining multiplier bits are zero.
module mips_muldiv #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  input  logic            hi_we,
  input  logic            lo_we,
  input  logic [XLEN-1:0] wdata,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic                is_div;
  logic                neg_a;
  logic                neg_b;
  logic [XLEN-1:0]     a_orig;

  // Multiply datapath: left-shifting multiplicand, right-shifting multiplier.
  logic [2*XLEN-1:0]   prod;
  logic [2*XLEN-1:0]   mcand;
  logic [XLEN-1:0]     mplier;

  // Divide datapath: partial remainder, dividend shifting into quotient.
  logic [XLEN-1:0]     rem;
  logic [XLEN-1:0]     quo;
  logic [XLEN-1:0]     dvsr;

  logic                op_signed;
  logic [XLEN-1:0]     abs_a;
  logic [XLEN-1:0]     abs_b;
  logic [XLEN:0]       trial;
  logic                trial_ok;
  logic                last_iter;
  logic [2*XLEN-1:0]   prod_fix;
  logic [XLEN-1:0]     quo_fix;
  logic [XLEN-1:0]     rem_fix;

  // NOTE: every always_comb output gets a default first so no path can leave it unassigned and infer a latch.
  always_comb begin
    op_signed = ~op[0];
    abs_a     = (op_signed && A[XLEN-1]) ? -A : A;
    abs_b     = (op_signed && B[XLEN-1]) ? -B : B;

    trial     = {rem, quo[XLEN-1]} - {1'b0, dvsr};
    trial_ok  = ~trial[XLEN];

    last_iter = (cnt == CNT_W'(XLEN - 1));
`ifdef MULDIV_EARLY_TERM_EN
    if (!is_div && ((mplier >> 1) == '0)) last_iter = 1'b1;
`endif

    prod_fix  = (neg_a ^ neg_b) ? -prod : prod;
    quo_fix   = (neg_a ^ neg_b) ? -quo  : quo;
    rem_fix   = neg_a ? -rem : rem;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      is_div <= 1'b0;
      neg_a  <= 1'b0;
      neg_b  <= 1'b0;
      a_orig <= '0;
      prod   <= '0;
      mcand  <= '0;
      mplier <= '0;
      rem    <= '0;
      quo    <= '0;
      dvsr   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            is_div <= op[1];
            neg_a  <= op_signed & A[XLEN-1];
            neg_b  <= op_signed & B[XLEN-1];
            a_orig <= A;
            prod   <= '0;
            mcand  <= {{XLEN{1'b0}}, abs_a};
            mplier <= abs_b;
            rem    <= '0;
            quo    <= abs_a;
            dvsr   <= abs_b;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= RUN;
          end else begin
            // MTHI/MTLO only land when nothing is launching or running.
            if (hi_we) hi <= wdata;
            if (lo_we) lo <= wdata;
          end
        end

        RUN: begin
          if (is_div) begin
            rem <= trial_ok ? trial[XLEN-1:0] : {rem[XLEN-2:0], quo[XLEN-1]};
            quo <= {quo[XLEN-2:0], trial_ok};
          end else begin
            if (mplier[0]) prod <= prod + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
          end
          cnt <= cnt + 1'b1;
          if (last_iter) state <= FIN;
        end

        FIN: begin
          if (is_div) begin
            // Divide by zero returns all-ones quotient and the untouched dividend.
            if (dvsr == '0) begin
              lo <= '1;
              hi <= a_orig;
            end else begin
              lo <= quo_fix;
              hi <= rem_fix;
            end
          end else begin
            {hi, lo} <= prod_fix;
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
